// File: rtl/framebuffer_write.sv
// framebuffer_write: Avalon-MM write master filling a framebuffer in HPS SDRAM
// through a 64-bit f2h_sdram port. Pixels (index + colour) are merged pairwise
// into 64-bit words in a hold register, queued in a small FIFO and written as
// single-beat transfers. Optional hardware clear is enabled by defining FB_CLEAR_EN.
module framebuffer_write #(
  parameter logic [28:0] FB0_BASE     = 29'h0600_0000,
  parameter logic [28:0] FB1_BASE     = 29'h0602_5800,
  parameter int          PIXELS       = 307200,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          HOLD_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        buffer,
  input  logic [18:0] pixel_addr,
  input  logic [31:0] pixel_colour,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        flush,
  output logic        idle,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write,
  input  logic        waitrequest,
  input  logic        clear_start,
  input  logic [31:0] clear_colour,
  output logic        clear_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [CW-1:0] LP_ONE_C    = CW'(1);
  localparam logic [CW-1:0] LP_FULL     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_HIGH     = CW'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] LP_TMO_LAST = TW'(HOLD_TIMEOUT - 1);
  localparam logic [18:0]   LP_PIXELS   = 19'(PIXELS);

  typedef struct packed {
    logic        buf_sel;
    logic [17:0] word;
    logic [63:0] data;
    logic [7:0]  be;
  } entry_t;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  // Avalon word address of an entry: selected framebuffer base plus word index
  function automatic logic [28:0] word_address(input entry_t e);
    return (e.buf_sel ? FB1_BASE : FB0_BASE) + {11'd0, e.word};
  endfunction

  entry_t          r_hold;
  logic            r_hold_valid;
  logic [TW-1:0]   r_tmo;
  logic            r_flush_pending;
  entry_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  state_t          r_state;
  logic [28:0]     r_address;
  logic [63:0]     r_writedata;
  logic [7:0]      r_byteenable;
  logic            r_write;
  logic            r_pixel_ready;
  logic            r_clear_busy;

  entry_t          w_new_entry;
  entry_t          w_merge_entry;
  entry_t          w_hold_next;
  entry_t          w_push_entry;
  entry_t          w_head;
  entry_t          w_head_next;
  logic            w_hold_valid_next;
  logic [TW-1:0]   w_tmo_next;
  logic [CW-1:0]   w_count_next;
  logic            w_accept;
  logic            w_in_range;
  logic            w_same;
  logic            w_tmo_hit;
  logic            w_pop;
  logic            w_room;
  logic            w_push;
  logic            w_flush_next;
  logic            w_busy_next;
  logic            w_ready_next;
  logic            w_idle;
  logic            w_clear_push;
  entry_t          w_clear_entry;

  assign w_accept    = pixel_valid && r_pixel_ready;
  assign w_in_range  = pixel_addr < LP_PIXELS;
  assign w_same      = (r_hold.buf_sel == buffer) && (r_hold.word == pixel_addr[18:1]);
  assign w_tmo_hit   = (r_tmo == LP_TMO_LAST);
  assign w_pop       = (r_state == ST_WRITE) && !waitrequest;
  assign w_room      = (r_count != LP_FULL) || w_pop;
  assign w_head      = r_mem[r_rd];
  assign w_head_next = r_mem[r_rd + AW'(1)];
  assign w_idle      = !r_hold_valid && (r_count == '0) && (r_state == ST_IDLE) &&
                       !r_flush_pending && !r_clear_busy;

`ifdef FB_CLEAR_EN
  localparam logic [17:0] LP_CLEAR_LAST = 18'(PIXELS / 2 - 1);
  logic        r_clear_pushing;
  logic [17:0] r_clear_n;
  logic        r_clear_buf;
  logic [31:0] r_clear_colour;
  logic        w_clear_start;

  assign w_clear_start = clear_start && w_idle && !w_accept;
  assign w_clear_push  = r_clear_pushing && w_room && !w_accept && !r_hold_valid;
  assign w_clear_entry = '{buf_sel: r_clear_buf, word: r_clear_n,
                           data: {2{r_clear_colour}}, be: 8'hFF};

  // Clear sequencer: latch target and colour at start, step the word index per push
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clear_pushing <= 1'b0;
      r_clear_n       <= 18'd0;
      r_clear_buf     <= 1'b0;
      r_clear_colour  <= 32'd0;
    end else if (w_clear_start) begin
      r_clear_pushing <= 1'b1;
      r_clear_n       <= 18'd0;
      r_clear_buf     <= buffer;
      r_clear_colour  <= clear_colour;
    end else if (w_clear_push) begin
      r_clear_n <= r_clear_n + 18'd1;
      if (r_clear_n == LP_CLEAR_LAST) begin
        r_clear_pushing <= 1'b0;
      end
    end
  end

  // Busy from start until the final clear word has been accepted on the bus
  always_comb begin
    w_busy_next = r_clear_busy;
    if (w_clear_start) begin
      w_busy_next = 1'b1;
    end else if (r_clear_busy && !r_clear_pushing && w_pop && (r_count == LP_ONE_C)) begin
      w_busy_next = 1'b0;
    end else begin
      w_busy_next = r_clear_busy;
    end
  end
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{clear_start, clear_colour};
  assign w_clear_push   = 1'b0;
  assign w_clear_entry  = '0;
  assign w_busy_next    = 1'b0;
`endif

  // Incoming pixel as a fresh one-lane entry, and as a merge into the hold word
  always_comb begin
    w_new_entry.buf_sel = buffer;
    w_new_entry.word    = pixel_addr[18:1];
    w_merge_entry       = r_hold;
    if (pixel_addr[0]) begin
      w_new_entry.data            = {pixel_colour, 32'h0};
      w_new_entry.be              = 8'hF0;
      w_merge_entry.data[63:32]   = pixel_colour;
      w_merge_entry.be[7:4]       = 4'hF;
    end else begin
      w_new_entry.data            = {32'h0, pixel_colour};
      w_new_entry.be              = 8'h0F;
      w_merge_entry.data[31:0]    = pixel_colour;
      w_merge_entry.be[3:0]       = 4'hF;
    end
  end

  // Hold/timeout next state and the single FIFO push port (pixel, drain or clear)
  always_comb begin
    w_hold_next       = r_hold;
    w_hold_valid_next = r_hold_valid;
    w_tmo_next        = r_tmo;
    w_push            = 1'b0;
    w_push_entry      = r_hold;
    if (w_accept) begin
      w_tmo_next = '0;
      if (!w_in_range) begin
        w_hold_next = r_hold;
      end else if (!r_hold_valid) begin
        w_hold_next       = w_new_entry;
        w_hold_valid_next = 1'b1;
      end else if (w_same) begin
        w_hold_next = w_merge_entry;
      end else begin
        w_push      = 1'b1;
        w_hold_next = w_new_entry;
      end
    end else if (r_hold_valid) begin
      if ((w_tmo_hit || r_flush_pending) && w_room) begin
        w_push            = 1'b1;
        w_hold_valid_next = 1'b0;
        w_tmo_next        = '0;
      end else if (!w_tmo_hit) begin
        w_tmo_next = r_tmo + TW'(1);
      end else begin
        w_tmo_next = r_tmo;
      end
    end else if (w_clear_push) begin
      w_tmo_next   = '0;
      w_push       = 1'b1;
      w_push_entry = w_clear_entry;
    end else begin
      w_tmo_next = '0;
    end
  end

  // FIFO occupancy, flush tracking and registered ready look-ahead
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + LP_ONE_C;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - LP_ONE_C;
    end else begin
      w_count_next = r_count;
    end
    w_flush_next = (flush || r_flush_pending) && w_hold_valid_next;
    w_ready_next = (w_count_next < LP_HIGH) && !w_flush_next && !w_busy_next;
  end

  // Hold register, timeout counter, flush flag and ready
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold          <= '0;
      r_hold_valid    <= 1'b0;
      r_tmo           <= '0;
      r_flush_pending <= 1'b0;
      r_pixel_ready   <= 1'b0;
      r_clear_busy    <= 1'b0;
    end else begin
      r_hold          <= w_hold_next;
      r_hold_valid    <= w_hold_valid_next;
      r_tmo           <= w_tmo_next;
      r_flush_pending <= w_flush_next;
      r_pixel_ready   <= w_ready_next;
      r_clear_busy    <= w_busy_next;
    end
  end

  // FIFO storage array (contents need no reset; pointers qualify them)
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Bus FSM: present FIFO head, hold it through waitrequest, chain back-to-back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_address    <= 29'd0;
      r_writedata  <= 64'd0;
      r_byteenable <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_count != '0) begin
            r_address    <= word_address(w_head);
            r_writedata  <= w_head.data;
            r_byteenable <= w_head.be;
            r_write      <= 1'b1;
            r_state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!waitrequest) begin
            if (r_count > LP_ONE_C) begin
              r_address    <= word_address(w_head_next);
              r_writedata  <= w_head_next.data;
              r_byteenable <= w_head_next.be;
            end else begin
              r_write <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_write <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pixel_ready = r_pixel_ready;
  assign idle        = w_idle;
  assign address     = r_address;
  assign burstcount  = 8'd1;
  assign writedata   = r_writedata;
  assign byteenable  = r_byteenable;
  assign write       = r_write;
  assign clear_busy  = r_clear_busy;

endmodule
